// File: rtl/ram_loader.sv
// ram_loader: assembles a byte stream into 16-bit words and writes them
// to consecutive addresses of a 16K-word RAM, starting at base_addr.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a load (accepted only while idle)
//   base_addr, word_count first address and number of words (0..16384)
//   byte_in, byte_valid,
//   byte_ready            byte stream handshake
//   mem_out               combinational RAM read data at mem_address
//   mem_address, mem_in,
//   mem_load              RAM address, write data, write enable
//   busy, done, error     status: not idle, completion pulse, verify miss
//   words_written         words written by the current/last load
//
// Parameter HI_FIRST: 1 = first byte of a pair is bits [15:8].
// Build option LOADER_VERIFY_EN: read back and compare each word
// after writing it; a miss sets error and ends the load.

module ram_loader #(
    parameter int HI_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] base_addr,
    input  logic [14:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [15:0] mem_out,
    output logic [13:0] mem_address,
    output logic [15:0] mem_in,
    output logic        mem_load,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [14:0] words_written
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV_A = 3'd1,
        RECV_B = 3'd2,
        WRITE  = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV_A = 3'd1,
        RECV_B = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd5
    } state_t;
`endif

    state_t      state;
    state_t      state_d;
    logic [13:0] addr_q;
    logic [14:0] count_q;
    logic [15:0] word_q;
    logic [14:0] written_q;

    logic        xfer;
    logic        last;
    logic        advance;
    logic        miss;
    logic [14:0] written_inc;

    assign xfer        = byte_valid && byte_ready;
    assign written_inc = written_q + 15'd1;
    assign last        = (written_inc == count_q);

`ifdef LOADER_VERIFY_EN
    logic error_q;

    assign miss    = (state == VERIFY) && (mem_out != word_q);
    assign advance = (state == VERIFY) && (mem_out == word_q);
    assign error   = error_q;
`else
    logic unused_mem_out;

    // Without read-back the RAM data is not needed.
    assign unused_mem_out = ^mem_out;
    assign miss    = 1'b0;
    assign advance = (state == WRITE);
    assign error   = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != 15'd0) begin
                        state_d = RECV_A;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RECV_A: begin
                if (xfer) begin
                    state_d = RECV_B;
                end
            end
            RECV_B: begin
                if (xfer) begin
                    state_d = WRITE;
                end
            end
`ifdef LOADER_VERIFY_EN
            WRITE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                if (miss || last) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV_A;
                end
            end
`else
            WRITE: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV_A;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= 14'd0;
            count_q   <= 15'd0;
            word_q    <= 16'd0;
            written_q <= 15'd0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                written_q <= 15'd0;
                if (word_count != 15'd0) begin
                    addr_q  <= base_addr;
                    count_q <= word_count;
                end
            end
            if (state == RECV_A && xfer) begin
                if (HI_FIRST != 0) begin
                    word_q[15:8] <= byte_in;
                end else begin
                    word_q[7:0] <= byte_in;
                end
            end
            if (state == RECV_B && xfer) begin
                if (HI_FIRST != 0) begin
                    word_q[7:0] <= byte_in;
                end else begin
                    word_q[15:8] <= byte_in;
                end
            end
            // 14-bit address wraps 16383 -> 0 on its own.
            if (advance) begin
                written_q <= written_inc;
                addr_q    <= addr_q + 14'd1;
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (state == IDLE && start) begin
            error_q <= 1'b0;
        end else if (miss) begin
            error_q <= 1'b1;
        end
    end
`endif

    assign byte_ready    = (state == RECV_A) || (state == RECV_B);
    assign busy          = (state != IDLE);
    // Gated by reset so an abort never writes or signals completion.
    assign mem_load      = (state == WRITE) && !reset;
    assign done          = (state == DONE) && !reset;
    assign mem_address   = addr_q;
    assign mem_in        = word_q;
    assign words_written = written_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: random and directed loads of ram_loader against a
// word-level reference image of the RAM.

module tb_ram_loader;

    localparam int HI = 1;
`ifdef LOADER_VERIFY_EN
    localparam int CPW = 4;
`else
    localparam int CPW = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_out;
    logic [13:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic        busy;
    logic        done;
    logic        error;
    logic [14:0] words_written;

    logic [15:0] ram [16384];
    logic [15:0] exp_ram [16384];
    int          wr_cnt [16384];
    logic        wr_clr = 1'b0;
    logic        force_b0 = 1'b0;
    logic [7:0]  byte_q [$];

    int checks = 0;
    int failures = 0;

    ram_loader #(.HI_FIRST(HI)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_out(mem_out),
        .mem_address(mem_address),
        .mem_in(mem_in),
        .mem_load(mem_load),
        .busy(busy),
        .done(done),
        .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_clr) begin
            for (int i = 0; i < 16384; i++) wr_cnt[i] <= 0;
        end else if (mem_load) begin
            ram[mem_address]    <= mem_in;
            wr_cnt[mem_address] <= wr_cnt[mem_address] + 1;
        end
    end

    assign mem_out = ram[mem_address] & (force_b0 ? 16'hFFFE : 16'hFFFF);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] wrap(input int a);
        return 14'(a % 16384);
    endfunction

    // Random bytes for cnt words; reference image gets the words.
    task automatic prep(input logic [13:0] base, input int cnt);
        logic [7:0] b0;
        logic [7:0] b1;
        for (int i = 0; i < cnt; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            byte_q.push_back(b0);
            byte_q.push_back(b1);
            exp_ram[wrap(int'(base) + i)] = (HI != 0) ? {b0, b1} : {b1, b0};
        end
    endtask

    function automatic int region_bad(input logic [13:0] base, input int cnt);
        int bad = 0;
        for (int i = 0; i < cnt; i++) begin
            if (ram[wrap(int'(base) + i)] !== exp_ram[wrap(int'(base) + i)])
                bad++;
        end
        return bad;
    endfunction

    // mode 0: valid always, 1: toggles, 2: random plus stray starts.
    task automatic run_load(input logic [13:0] base, input int cnt,
                            input int mode, input int rst_at,
                            output int loads, output int dones,
                            output int lat, output int ww);
        int  bound;
        bit  v;
        loads = 0;
        dones = 0;
        lat   = -1;
        bound = (mode == 0) ? CPW * cnt + 12 : 12 * cnt + 40;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = 15'(cnt);
        byte_valid = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst_at >= 0 && k == rst_at + 1) begin
                check("rst_abort_outs",
                      {byte_ready, mem_load, busy, done, error,
                       mem_address, mem_in, words_written}, 0);
                reset = 1'b0;
            end
            if (k == 1) check("busy_run", busy, 1);
            if (done) begin
                dones++;
                if (lat < 0) lat = k;
            end
            if (mem_load) loads++;
            if (rst_at >= 0 && k == rst_at) reset = 1'b1;
            if (mode == 2 && lat < 0 && $urandom_range(0, 7) == 0) begin
                start      = 1'b1;
                base_addr  = 14'($urandom);
                word_count = 15'($urandom_range(0, 3));
            end
            v = (mode == 0) ? 1'b1 :
                (mode == 1) ? k[0] : ($urandom_range(0, 9) < 7);
            byte_valid = v && (byte_q.size() > 0);
            if (byte_q.size() > 0) byte_in = byte_q[0];
            if (byte_valid && byte_ready) void'(byte_q.pop_front());
            if (lat >= 0 && k >= lat + 3) break;
            if (rst_at >= 0 && k >= rst_at + 4) break;
        end
        if (lat < 0 && rst_at < 0) check("done_timeout", 0, 1);
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_q.delete();
        ww = int'(words_written);
    endtask

    initial begin
        int          loads;
        int          dones;
        int          lat;
        int          ww;
        int          bad;
        int          cnt;
        logic [13:0] base;
        logic [15:0] saved;

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 14'd0;
        word_count = 15'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {byte_ready, mem_load, busy, done, error,
                             mem_address, mem_in, words_written}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {byte_ready, busy}, 0);

        // Full 16K load: every address exactly once, wrapping.
        wr_clr = 1'b1;
        @(negedge clk);
        wr_clr = 1'b0;
        base = 14'($urandom);
        prep(base, 16384);
        run_load(base, 16384, 0, -1, loads, dones, lat, ww);
        check("full_loads", loads, 16384);
        check("full_dones", dones, 1);
        check("full_ww", ww, 16384);
        check("full_lat", lat, CPW * 16384 + 1);
        check("full_data", region_bad(base, 16384), 0);
        bad = 0;
        for (int i = 0; i < 16384; i++) if (wr_cnt[i] != 1) bad++;
        check("full_once", bad, 0);
        check("full_err", error, 0);

        // Two words at 0x0010.
        byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(14'h0010, 2, 0, -1, loads, dones, lat, ww);
        check("v1_w0", ram[14'h0010], (HI != 0) ? 16'h1234 : 16'h3412);
        check("v1_w1", ram[14'h0011], (HI != 0) ? 16'h5678 : 16'h7856);
        check("v1_dones", dones, 1);
        check("v1_ww", ww, 2);
        check("v1_loads", loads, 2);
        check("v1_lat", lat, CPW * 2 + 1);

        // Wrap from the top address.
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(14'h3FFF, 2, 0, -1, loads, dones, lat, ww);
        check("wrap_w0", ram[14'h3FFF], (HI != 0) ? 16'hAABB : 16'hBBAA);
        check("wrap_w1", ram[14'h0000], (HI != 0) ? 16'hCCDD : 16'hDDCC);
        check("wrap_ww", ww, 2);

        // Zero-length load.
        run_load(14'h0123, 0, 0, -1, loads, dones, lat, ww);
        check("zero_loads", loads, 0);
        check("zero_dones", dones, 1);
        check("zero_lat", lat <= 2, 1);
        check("zero_ww", ww, 0);

        // Valid toggling every cycle.
        base = 14'h0400;
        prep(base, 3);
        run_load(base, 3, 1, -1, loads, dones, lat, ww);
        check("tog_data", region_bad(base, 3), 0);
        check("tog_loads", loads, 3);
        check("tog_dones", dones, 1);

        // Reset while receiving the second byte of word 2.
        base  = 14'h2000;
        saved = ram[14'h2001];
        byte_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        run_load(base, 3, 0, CPW + 2, loads, dones, lat, ww);
        check("rst_w1", ram[14'h2000], (HI != 0) ? 16'hA1B2 : 16'hB2A1);
        check("rst_w2", ram[14'h2001], saved);
        check("rst_loads", loads, 1);
        check("rst_dones", dones, 0);

        // Randomized loads, some near the wrap point.
        for (int n = 0; n < 10; n++) begin
            cnt  = $urandom_range(1, 20);
            base = (n % 3 == 0) ? 14'(16384 - $urandom_range(1, 10))
                                : 14'($urandom);
            prep(base, cnt);
            run_load(base, cnt, 2, -1, loads, dones, lat, ww);
            check("rnd_data", region_bad(base, cnt), 0);
            check("rnd_loads", loads, cnt);
            check("rnd_dones", dones, 1);
            check("rnd_ww", ww, cnt);
            check("rnd_err", error, 0);
        end

`ifdef LOADER_VERIFY_EN
        // Read-back sees bit 0 stuck low: first word must miss.
        force_b0 = 1'b1;
        byte_q = (HI != 0) ? '{8'h00, 8'h01, 8'h00, 8'h03}
                           : '{8'h01, 8'h00, 8'h03, 8'h00};
        run_load(14'h0100, 2, 0, -1, loads, dones, lat, ww);
        check("ver_err", error, 1);
        check("ver_loads", loads, 1);
        check("ver_dones", dones, 1);
        check("ver_ww", ww, 0);
        force_b0 = 1'b0;
        run_load(14'h0100, 0, 0, -1, loads, dones, lat, ww);
        check("ver_err_clr", error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
